// File: rtl/p_xor_descrambler_if.sv
// Handshake bundle for p_xor_descrambler: upstream/downstream valid-ready,
// data words, seed reload and delivery count.
interface p_xor_descrambler_if #(
    parameter int BUS_WIDTH  = 4,
    parameter int LFSR_WIDTH = 16
);
    logic                  in_seed_load;
    logic [LFSR_WIDTH-1:0] in_seed;
    logic                  in_valid;
    logic                  out_ready;
    logic [BUS_WIDTH-1:0]  in_bus;
    logic                  out_valid;
    logic                  in_ready;
    logic [BUS_WIDTH-1:0]  out_bus;
    logic [15:0]           out_count;

    modport slave (
        input  in_seed_load, in_seed, in_valid, in_bus, in_ready,
        output out_ready, out_valid, out_bus, out_count
    );

    modport master (
        output in_seed_load, in_seed, in_valid, in_bus, in_ready,
        input  out_ready, out_valid, out_bus, out_count
    );
endinterface

// File: rtl/p_xor_descrambler.sv
// Additive descrambler: XORs each accepted word with the low bits of a Galois
// LFSR, which then advances BUS_WIDTH steps; one registered output stage.
module p_xor_descrambler #(
    parameter int                    BUS_WIDTH  = 4,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] POLY       = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1
) (
    input logic               in_clk,
    input logic               in_reset,
    p_xor_descrambler_if.slave io
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state, state_next;
    logic [LFSR_WIDTH-1:0] lfsr, lfsr_adv, lfsr_next;
    logic [BUS_WIDTH-1:0]  out_bus_q;
    logic [15:0]           count_q;
    logic                  ready, accept, deliver;

    assign ready   = (state == EMPTY) || io.in_ready;
    assign accept  = io.in_valid && ready;
    assign deliver = (state == FULL) && io.in_ready;

    assign io.out_ready = ready;
    assign io.out_valid = (state == FULL);
    assign io.out_bus   = out_bus_q;
    assign io.out_count = count_q;

    // BUS_WIDTH Galois steps unrolled into one cycle.
    // NOTE: blocking assignments here are intentional; each loop iteration
    // must see the previous step's value within the same combinational pass.
    always_comb begin
        lfsr_adv = lfsr;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            if (lfsr_adv[0]) lfsr_adv = (lfsr_adv >> 1) ^ POLY;
            else             lfsr_adv = lfsr_adv >> 1;
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        state_next = state;
        lfsr_next  = lfsr;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (deliver && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
        // Reload wins over advance; an all-zero seed would lock the LFSR.
        if (io.in_seed_load)
            lfsr_next = (io.in_seed == '0) ? SEED : io.in_seed;
        else if (accept)
            lfsr_next = lfsr_adv;
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state     <= EMPTY;
            lfsr      <= SEED;
            out_bus_q <= '0;
            count_q   <= '0;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
            if (accept)  out_bus_q <= io.in_bus ^ lfsr[BUS_WIDTH-1:0];
            if (deliver) count_q   <= count_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_p_xor_descrambler.sv
// Directed bench for p_xor_descrambler: streaming table, backpressure, seed
// reload, asynchronous reset and delivery-counter wrap.
module tb_p_xor_descrambler;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    p_xor_descrambler_if #(.BUS_WIDTH(4), .LFSR_WIDTH(16)) io ();

    p_xor_descrambler dut (
        .in_clk   (clk),
        .in_reset (rst),
        .io       (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bus_in;
        logic [3:0] bus_exp;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [15:0] actual,
                         input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Keystream after reset: 1, E, 4, C, 2 (LFSR ACE1,1C4E,C2C4,562C,EB62).
        vecs[0] = '{4'b1101, 4'b1100};
        vecs[1] = '{4'b1011, 4'b0101};
        vecs[2] = '{4'b0111, 4'b0011};
        vecs[3] = '{4'b0000, 4'b1100};
        vecs[4] = '{4'b1111, 4'b1101};

        rst = 1'b1;
        io.in_seed_load = 1'b0;
        io.in_seed      = '0;
        io.in_valid     = 1'b0;
        io.in_bus       = '0;
        io.in_ready     = 1'b0;
        step();
        check("reset out_valid", {15'd0, io.out_valid}, 16'd0);
        check("reset out_bus", {12'd0, io.out_bus}, 16'd0);
        check("reset out_count", io.out_count, 16'd0);
        check("reset out_ready", {15'd0, io.out_ready}, 16'd1);
        do_reset();

        // Streaming with no backpressure: one word per cycle, no bubbles.
        io.in_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            io.in_valid = 1'b1;
            io.in_bus   = vecs[i].bus_in;
            step();
            check($sformatf("stream valid %0d", i), {15'd0, io.out_valid}, 16'd1);
            check($sformatf("stream bus %0d", i), {12'd0, io.out_bus}, {12'd0, vecs[i].bus_exp});
            check($sformatf("stream count %0d", i), io.out_count, 16'(i));
        end
        io.in_valid = 1'b0;
        step();
        check("stream drain valid", {15'd0, io.out_valid}, 16'd0);
        check("stream drain count", io.out_count, 16'd5);

        // Backpressure: held word stays, pending word not consumed.
        do_reset();
        io.in_ready = 1'b0;
        io.in_valid = 1'b1;
        io.in_bus   = 4'b1101;
        step();
        io.in_bus = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp hold bus %0d", i), {12'd0, io.out_bus}, 16'h000C);
            check($sformatf("bp ready low %0d", i), {15'd0, io.out_ready}, 16'd0);
            step();
        end
        check("bp count held", io.out_count, 16'd0);
        io.in_ready = 1'b1;
        #1;
        check("bp ready passthrough", {15'd0, io.out_ready}, 16'd1);
        step();
        check("bp pending bus", {12'd0, io.out_bus}, 16'h0005);
        check("bp count", io.out_count, 16'd1);

        // Asynchronous reset while FULL and stalled.
        io.in_valid = 1'b0;
        io.in_ready = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        check("async rst valid", {15'd0, io.out_valid}, 16'd0);
        check("async rst count", io.out_count, 16'd0);
        check("async rst bus", {12'd0, io.out_bus}, 16'd0);
        #1 rst = 1'b0;
        io.in_valid = 1'b1;
        io.in_bus   = 4'b1101;
        step();
        check("post rst keystream", {12'd0, io.out_bus}, 16'h000C);

        // Seed reload: zero seed maps to ACE1; load-cycle word uses old stream.
        do_reset();
        io.in_ready = 1'b1;
        io.in_valid = 1'b1;
        io.in_bus   = 4'b1101;
        step();
        io.in_valid     = 1'b0;
        io.in_seed_load = 1'b1;
        io.in_seed      = 16'h0000;
        step();
        io.in_seed  = 16'h1235;
        io.in_valid = 1'b1;
        io.in_bus   = 4'b0000;
        step();
        check("seed old keystream", {12'd0, io.out_bus}, 16'h0001);
        io.in_seed_load = 1'b0;
        step();
        check("seed new keystream", {12'd0, io.out_bus}, 16'h0005);
        io.in_valid     = 1'b0;
        io.in_ready     = 1'b0;
        io.in_seed_load = 1'b1;
        io.in_seed      = 16'hFFFF;
        step();
        io.in_seed_load = 1'b0;
        check("seed held word", {12'd0, io.out_bus}, 16'h0005);
        check("seed held valid", {15'd0, io.out_valid}, 16'd1);

        // Delivery counter wrap.
        do_reset();
        io.in_ready = 1'b1;
        io.in_valid = 1'b1;
        io.in_bus   = 4'b0000;
        repeat (65536) step();
        check("count near wrap", io.out_count, 16'hFFFF);
        step();
        check("count wrapped", io.out_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/p_xor_descrambler.md
Name: p_xor_descrambler

Overview:
- Additive stream descrambler for the boolean datapath.
- XORs each incoming BUS_WIDTH word with a keystream word taken from an internal Galois LFSR, recovering data that a matching scrambler XORed with the same keystream.
- Sits between a scrambled-word producer and a consumer, with valid/ready handshakes on both sides and a single registered output stage.
- The LFSR can be reseeded at run time to resynchronise with the scrambler.

Parameters:
- BUS_WIDTH, 4: data word width. Legal range 1 to LFSR_WIDTH.
- LFSR_WIDTH, 16: LFSR state width.
- POLY, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1: LFSR state after reset. Also substituted for any all-zero seed.

Ports:
- in_clk, input, 1: the only clock. All state updates on its rising edge.
- in_reset, input, 1: asynchronous, active-high reset.
- in_seed_load, input, 1: load in_seed into the LFSR this cycle.
- in_seed, input, LFSR_WIDTH: new LFSR seed.
- in_valid, input, 1: upstream word present on in_bus.
- out_ready, output, 1: block can accept an upstream word.
- in_bus, input, BUS_WIDTH: scrambled word.
- out_valid, output, 1: descrambled word present on out_bus.
- in_ready, input, 1: downstream accepts out_bus.
- out_bus, output, BUS_WIDTH: descrambled word.
- out_count, output, 16: number of words delivered downstream.

Behaviour:
- Reset (asynchronous, immediate): lfsr=SEED, state=EMPTY, out_valid=0, out_bus=0, out_count=0.
  - Reset mid-transfer discards the held word without delivering it.
  - out_ready is combinational, so it reads 1 during reset.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1, out_bus held stable.
- out_ready = (state==EMPTY) || in_ready. Combinational, so a word can pass through with no bubble.
- Accept condition: in_valid && out_ready.
  - On accept, out_bus <= in_bus ^ lfsr[BUS_WIDTH-1:0] and state <= FULL.
  - Latency: one cycle from accept to out_valid.
- Deliver condition: out_valid && in_ready. On deliver, out_count <= out_count+1, wrapping 16'hFFFF to 0.
- State transitions:
  - EMPTY + accept: FULL.
  - FULL + deliver without accept: EMPTY.
  - FULL + deliver + accept in the same cycle: stays FULL with the new word.
  - FULL + !in_ready: hold out_bus and out_valid unchanged. out_ready=0.
- LFSR advance: after each accept, the LFSR advances exactly BUS_WIDTH single Galois steps within that one clock (unrolled combinationally).
  - Single step: b=s[0]; s=s>>1; if b, s=s^POLY.
  - The LFSR never advances without an accept.
- Seed load:
  - On in_seed_load, lfsr <= (in_seed==0) ? SEED : in_seed.
  - Load has priority over advance.
  - A word accepted in the same cycle is XORed with the old keystream. The next accepted word uses the new seed.
  - A word already held in FULL is unaffected by the load.
- in_valid while out_ready=0: no accept, and the LFSR does not move. Upstream must hold the word until accepted.
- in_bus is ignored when in_valid=0.

Test Plan:
- Reset, then in_valid=1, in_bus=4'b1101, in_ready=1 -> next cycle out_valid=1, out_bus=4'b1100 (keystream 4'h1). out_count goes 0->1 on the following edge.
- Back-to-back accepts with in_bus 4'b1101 then 4'b1011, in_ready=1 -> out_bus 4'b1100 then 4'b0101 (second keystream 4'hE, LFSR 16'h1C4E). No bubble cycles.
- Backpressure: accept 4'b1101 with in_ready=0 for 3 cycles -> out_bus stays 4'b1100, out_ready=0, LFSR stays at 16'h1C4E, and a pending in_valid is not consumed. Raise in_ready -> delivered, pending word accepted with keystream 4'hE.
- Seed load: in_seed_load=1, in_seed=16'h0000 -> LFSR=16'hACE1. Then in_seed=16'h1235 loaded in the same cycle as accepting 4'b0000 -> that word outputs 4'h1 (old keystream), and the next 4'b0000 outputs 4'h5.
- Reset asserted while FULL with in_ready=0 -> out_valid drops to 0 immediately (no clock edge), out_count=0. The first word after release uses keystream 4'h1.
- Counter wrap: 65536 deliveries -> out_count returns to 16'h0000.
